// File: rtl/fir_coef_sequencer_if.sv
// Host-side handshake bundle for the FIR coefficient sequencer.
// Carries the coefficient-set channel and the sample channel.
interface fir_coef_sequencer_if #(
  parameter int L = 32
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [L-1:0] cfg_coefs;
  logic         smp_valid;
  logic         smp_ready;
  logic [7:0]   smp_data;

  modport master (
    output cfg_valid, cfg_coefs, smp_valid, smp_data,
    input  cfg_ready, smp_ready
  );

  modport slave (
    input  cfg_valid, cfg_coefs, smp_valid, smp_data,
    output cfg_ready, smp_ready
  );
endinterface

// File: rtl/fir_coef_sequencer.sv
// Loads a coefficient set into the FIR datapath scan chain using two-phase
// non-overlapping shift clocks, then gates spaced sample strobes to the datapath.
module fir_coef_sequencer #(
  parameter int NTAPS = 4,
  parameter int CW    = 8,
  parameter int DIV   = 2,
  parameter int SGAP  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_coef_sequencer_if.slave  host,
  output logic [7:0]           fir_a,
  output logic                 fir_stb,
  output logic                 shift_in,
  output logic                 shift_clk1,
  output logic                 shift_clk2,
  output logic                 busy,
  output logic                 loaded
);

  localparam int L  = NTAPS * CW;
  localparam int BW = $clog2(L);
  localparam int DW = $clog2(DIV) + 1;
  localparam int GW = $clog2(SGAP) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PH1,
    LOW,
    PH2,
    FINISH
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [L-1:0]    shreg;
  logic [BW-1:0]   bitcnt;
  logic [DW-1:0]   divcnt;
  logic [GW-1:0]   gapcnt;
  logic            div_done;
  logic            last_bit;
  logic            cfg_hs;
  logic            smp_hs;

  assign host.cfg_ready = (state == IDLE);
  assign host.smp_ready = (state == IDLE) && loaded && !host.cfg_valid && (gapcnt == '0);
  assign cfg_hs   = host.cfg_valid && host.cfg_ready;
  assign smp_hs   = host.smp_valid && host.smp_ready;
  assign div_done = (divcnt == DW'(DIV - 1));
  assign last_bit = (bitcnt == BW'(L - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_hs)   state_next = SETUP;
      SETUP:   if (div_done) state_next = PH1;
      PH1:     if (div_done) state_next = LOW;
      LOW:     if (div_done) state_next = PH2;
      PH2:     if (div_done) state_next = last_bit ? FINISH : SETUP;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift clocks are registered from the next state so they align exactly with the phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bitcnt     <= '0;
      divcnt     <= '0;
      shift_in   <= 1'b0;
      shift_clk1 <= 1'b0;
      shift_clk2 <= 1'b0;
      busy       <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      if ((state_next != state) || (state == IDLE) || (state == FINISH)) begin
        divcnt <= '0;
      end else begin
        divcnt <= divcnt + 1'b1;
      end
      shift_clk1 <= (state_next == PH1);
      shift_clk2 <= (state_next == PH2);
      if (cfg_hs) begin
        shreg    <= {host.cfg_coefs[L-2:0], 1'b0};
        shift_in <= host.cfg_coefs[L-1];
        bitcnt   <= '0;
        busy     <= 1'b1;
        loaded   <= 1'b0;
      end else if ((state == PH2) && div_done && !last_bit) begin
        shreg    <= {shreg[L-2:0], 1'b0};
        shift_in <= shreg[L-1];
        bitcnt   <= bitcnt + 1'b1;
      end else if (state == FINISH) begin
        shift_in <= 1'b0;
        busy     <= 1'b0;
        loaded   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fir_a   <= '0;
      fir_stb <= 1'b0;
      gapcnt  <= '0;
    end else begin
      fir_stb <= smp_hs;
      if (smp_hs) begin
        fir_a  <= host.smp_data;
        gapcnt <= GW'(SGAP - 1);
      end else if (gapcnt != '0) begin
        gapcnt <= gapcnt - 1'b1;
      end
    end
  end

endmodule
